// File: rtl/servo_pwm_pkg.sv
`default_nettype none
// servo_pwm_pkg: frame timing constants, FSM encoding and error codes shared by both ends of the servo PWM link.
// Rev 1.0
package servo_pwm_pkg;

  localparam int CONF_PERIODO  = 1000000;
  localparam int LARGURA_0     = 28204;
  localparam int LARGURA_1     = 76115;
  localparam int TOL_LARGURA   = 2000;
  localparam int TOL_PERIODO   = 20000;
  localparam int CNT_W         = 21;
  localparam int FILTRO_CICLOS = 4;

  typedef enum logic [1:0] {
    INICIAL       = 2'd0,
    ESPERA_SUBIDA = 2'd1,
    MEDE_ALTO     = 2'd2,
    MEDE_BAIXO    = 2'd3
  } estado_t;

  localparam logic [1:0] ERRO_OK      = 2'b00;
  localparam logic [1:0] ERRO_LARGURA = 2'b01;
  localparam logic [1:0] ERRO_PERIODO = 2'b10;
  localparam logic [1:0] ERRO_TIMEOUT = 2'b11;

  // Inclusive window: |valor - nominal| <= tol.
  function automatic logic dentro_janela(input int valor, input int nominal, input int tol);
    return (valor >= nominal - tol) && (valor <= nominal + tol);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sincronizador_borda.sv
`default_nettype none
// sincronizador_borda: 2-FF synchronizer, optional glitch filter (DECODIFICADOR_FILTRO_EN) and registered edge pulses.
// Rev 1.0
module sincronizador_borda
`ifdef DECODIFICADOR_FILTRO_EN
  #(parameter int FILTRO_CICLOS = servo_pwm_pkg::FILTRO_CICLOS)
`endif
(
  input  logic clock,
  input  logic reset,
  input  logic pwm_in,
  output logic linha,
  output logic nivel,
  output logic subida,
  output logic descida,
  output logic ativo
);

  logic [1:0] sinc;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) sinc <= '0;
    else        sinc <= {sinc[0], pwm_in};
  end

`ifdef DECODIFICADOR_FILTRO_EN
  localparam int FW       = $clog2(FILTRO_CICLOS + 1);
  localparam int LATENCIA = 3 + FILTRO_CICLOS + 1;

  logic [FW-1:0] cont_filtro;
  logic          filtrado;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cont_filtro <= '0;
      filtrado    <= 1'b0;
    end else if (sinc[1] == filtrado) begin
      cont_filtro <= '0;
    end else if (cont_filtro == FW'(FILTRO_CICLOS - 1)) begin
      filtrado    <= sinc[1];
      cont_filtro <= '0;
    end else begin
      cont_filtro <= cont_filtro + 1'b1;
    end
  end

  assign linha = filtrado;
`else
  localparam int LATENCIA = 3;

  assign linha = sinc[1];
`endif

  // The reset value of the pipeline is not the real line level; ativo marks when it is.
  logic [LATENCIA-1:0] aquecido;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) aquecido <= '0;
    else        aquecido <= {aquecido[LATENCIA-2:0], 1'b1};
  end

  assign ativo = aquecido[LATENCIA-1];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      nivel   <= 1'b0;
      subida  <= 1'b0;
      descida <= 1'b0;
    end else begin
      nivel   <= linha;
      subida  <= linha & ~nivel;
      descida <= ~linha & nivel;
    end
  end

endmodule
`default_nettype wire

// File: rtl/decodificador_pwm_servo.sv
`default_nettype none
// decodificador_pwm_servo: measures servo PWM frames and decodes the 1-bit position; flags bad width/period/stuck line.
// Rev 1.0 -- optional glitch filter enabled by DECODIFICADOR_FILTRO_EN.
module decodificador_pwm_servo #(
  parameter int CONF_PERIODO = servo_pwm_pkg::CONF_PERIODO,
  parameter int LARGURA_0    = servo_pwm_pkg::LARGURA_0,
  parameter int LARGURA_1    = servo_pwm_pkg::LARGURA_1,
  parameter int TOL_LARGURA  = servo_pwm_pkg::TOL_LARGURA,
  parameter int TOL_PERIODO  = servo_pwm_pkg::TOL_PERIODO,
  parameter int CNT_W        = servo_pwm_pkg::CNT_W
`ifdef DECODIFICADOR_FILTRO_EN
  , parameter int FILTRO_CICLOS = servo_pwm_pkg::FILTRO_CICLOS
`endif
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] largura,
  output logic [CNT_W-1:0] periodo,
  output logic             posicao,
  output logic             valido,
  output logic [1:0]       erro,
  output logic             pronto,
  output logic [1:0]       db_estado,
  output logic             db_pwm
);

  import servo_pwm_pkg::*;

  localparam logic [CNT_W-1:0] CONT_MAX = CNT_W'(2 * CONF_PERIODO);

  logic nivel, subida, descida, ativo;

`ifdef DECODIFICADOR_FILTRO_EN
  sincronizador_borda #(.FILTRO_CICLOS(FILTRO_CICLOS)) u_sinc (
    .clock(clock), .reset(reset), .pwm_in(pwm_in), .linha(db_pwm),
    .nivel(nivel), .subida(subida), .descida(descida), .ativo(ativo)
  );
`else
  sincronizador_borda u_sinc (
    .clock(clock), .reset(reset), .pwm_in(pwm_in), .linha(db_pwm),
    .nivel(nivel), .subida(subida), .descida(descida), .ativo(ativo)
  );
`endif

  estado_t          estado, prox;
  logic [CNT_W-1:0] contador;
  logic [CNT_W-1:0] alto;
  logic             fecha, estouro;
  logic             periodo_ok, pos0_ok, pos1_ok;

  assign fecha   = (estado == MEDE_BAIXO) && subida;
  // An edge arriving on the saturation cycle still wins over the timeout.
  assign estouro = (contador == CONT_MAX) &&
                   (((estado == MEDE_ALTO) && !descida) || ((estado == MEDE_BAIXO) && !subida));

  assign periodo_ok = dentro_janela(int'(contador), CONF_PERIODO, TOL_PERIODO);
  assign pos0_ok    = dentro_janela(int'(alto), LARGURA_0, TOL_LARGURA);
  assign pos1_ok    = dentro_janela(int'(alto), LARGURA_1, TOL_LARGURA);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) estado <= INICIAL;
    else        estado <= prox;
  end

  always_comb begin
    prox = estado;
    case (estado)
      INICIAL:       if (ativo && !nivel) prox = ESPERA_SUBIDA;
      ESPERA_SUBIDA: if (subida) prox = MEDE_ALTO;
      MEDE_ALTO: begin
        if (descida)      prox = MEDE_BAIXO;
        else if (estouro) prox = INICIAL;
      end
      MEDE_BAIXO: begin
        if (subida)       prox = MEDE_ALTO;
        else if (estouro) prox = INICIAL;
      end
      default:            prox = INICIAL;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      contador <= '0;
    end else if (((estado == ESPERA_SUBIDA) && subida) || fecha) begin
      contador <= CNT_W'(1);
    end else if ((estado == MEDE_ALTO) || (estado == MEDE_BAIXO)) begin
      if (contador != CONT_MAX) contador <= contador + 1'b1;
    end else begin
      contador <= '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                                alto <= '0;
    else if ((estado == MEDE_ALTO) && descida) alto <= contador;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      largura <= '0;
      periodo <= '0;
      posicao <= 1'b0;
      valido  <= 1'b0;
      erro    <= ERRO_OK;
      pronto  <= 1'b0;
    end else begin
      pronto <= 1'b0;
      if (fecha) begin
        pronto  <= 1'b1;
        largura <= alto;
        periodo <= contador;
        if (!periodo_ok) begin
          valido <= 1'b0;
          erro   <= ERRO_PERIODO;
        end else if (pos0_ok) begin
          posicao <= 1'b0;
          valido  <= 1'b1;
          erro    <= ERRO_OK;
        end else if (pos1_ok) begin
          posicao <= 1'b1;
          valido  <= 1'b1;
          erro    <= ERRO_OK;
        end else begin
          valido <= 1'b0;
          erro   <= ERRO_LARGURA;
        end
      end else if (estouro) begin
        pronto <= 1'b1;
        valido <= 1'b0;
        erro   <= ERRO_TIMEOUT;
      end
    end
  end

  assign db_estado = estado;

endmodule
`default_nettype wire

// File: tb/tb_decodificador_pwm_servo.sv
`default_nettype none
// tb_decodificador_pwm_servo: scoreboard bench with scaled frame timing; a waveform-level model predicts every closed frame.
module tb_decodificador_pwm_servo;

  localparam int C    = 1000;
  localparam int L0   = 282;
  localparam int L1   = 761;
  localparam int TW   = 20;
  localparam int TP   = 20;
  localparam int W    = 12;
  localparam int CMAX = 2 * C;

  logic         clock  = 1'b0;
  logic         reset  = 1'b0;
  logic         pwm_in = 1'b0;
  logic [W-1:0] largura, periodo;
  logic         posicao, valido, pronto, db_pwm;
  logic [1:0]   erro, db_estado;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int larg;
    int per;
    int pos;
    int val;
    int err;
  } esp_t;

  esp_t fila[$];

  // Reference model state, in the input time domain
  int   m_est, m_el, m_hi, m_larg, m_per, m_pos;
  logic m_prev;
`ifdef DECODIFICADOR_FILTRO_EN
  logic m_flt;
  int   m_run;
`endif

  decodificador_pwm_servo #(
    .CONF_PERIODO(C), .LARGURA_0(L0), .LARGURA_1(L1),
    .TOL_LARGURA(TW), .TOL_PERIODO(TP), .CNT_W(W)
  ) dut (
    .clock(clock), .reset(reset), .pwm_in(pwm_in),
    .largura(largura), .periodo(periodo), .posicao(posicao), .valido(valido),
    .erro(erro), .pronto(pronto), .db_estado(db_estado), .db_pwm(db_pwm)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int absd(input int x);
    return (x < 0) ? -x : x;
  endfunction

  function automatic void fecha_quadro(input int h, input int p);
    esp_t e;
    m_larg = h;
    m_per  = p;
    e.larg = h;
    e.per  = p;
    if (absd(p - C) > TP) begin
      e.val = 0; e.err = 2;
    end else if (absd(h - L0) <= TW) begin
      m_pos = 0; e.val = 1; e.err = 0;
    end else if (absd(h - L1) <= TW) begin
      m_pos = 1; e.val = 1; e.err = 0;
    end else begin
      e.val = 0; e.err = 1;
    end
    e.pos = m_pos;
    fila.push_back(e);
  endfunction

  function automatic void tempo_esgotado();
    esp_t e;
    e.larg = m_larg;
    e.per  = m_per;
    e.pos  = m_pos;
    e.val  = 0;
    e.err  = 3;
    fila.push_back(e);
    m_est = 0;
  endfunction

  function automatic void modelo_reset(input logic linha);
    m_est  = 0;
    m_el   = 0;
    m_hi   = 0;
    m_larg = 0;
    m_per  = 0;
    m_pos  = 0;
    m_prev = linha;
`ifdef DECODIFICADOR_FILTRO_EN
    m_flt  = linha;
    m_run  = 0;
`endif
    fila.delete();
  endfunction

  // One input cycle: 0 wait low, 1 wait rise, 2 high, 3 low
  function automatic void passo(input logic v);
    logic l, sub, des;
    l = v;
`ifdef DECODIFICADOR_FILTRO_EN
    if (v == m_flt) m_run = 0;
    else begin
      m_run++;
      if (m_run == servo_pwm_pkg::FILTRO_CICLOS) begin
        m_flt = v;
        m_run = 0;
      end
    end
    l = m_flt;
`endif
    sub    = l & ~m_prev;
    des    = ~l & m_prev;
    m_prev = l;
    m_el++;
    case (m_est)
      0: if (!l) m_est = 1;
      1: if (sub) begin m_est = 2; m_el = 0; end
      2: begin
        if (des) begin m_hi = m_el; m_est = 3; end
        else if (m_el == CMAX) tempo_esgotado();
      end
      3: begin
        if (sub) begin fecha_quadro(m_hi, m_el); m_el = 0; m_est = 2; end
        else if (m_el == CMAX) tempo_esgotado();
      end
      default: m_est = 0;
    endcase
  endfunction

  task automatic drive(input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #2;
      pwm_in = v;
      passo(v);
    end
  endtask

  task automatic quadro(input int h, input int p);
    drive(1'b1, h);
    drive(1'b0, p - h);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_largura"}, int'(largura), 0);
    check({tag, "_periodo"}, int'(periodo), 0);
    check({tag, "_posicao"}, int'(posicao), 0);
    check({tag, "_valido"},  int'(valido), 0);
    check({tag, "_erro"},    int'(erro), 0);
    check({tag, "_pronto"},  int'(pronto), 0);
    check({tag, "_estado"},  int'(db_estado), 0);
  endtask

  always @(negedge clock) begin : monitor
    esp_t e;
    if (reset && pronto) begin
      if (fila.size() == 0) begin
        check("pronto_sem_quadro", 1, 0);
      end else begin
        e = fila.pop_front();
        check("largura", int'(largura), e.larg);
        check("periodo", int'(periodo), e.per);
        check("posicao", int'(posicao), e.pos);
        check("valido",  int'(valido),  e.val);
        check("erro",    int'(erro),    e.err);
      end
    end
  end

  initial begin
    #600000;
    check("watchdog", 1, 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    modelo_reset(1'b0);
    repeat (3) @(posedge clock);
    #1;
    check_zero("reset_inicial");
    @(posedge clock);
    #2;
    reset = 1'b1;
    drive(1'b0, 20);

    // Nominal position-0 frames, then position 1 with width window edges
    repeat (3) quadro(L0, C);
    quadro(L1, C);
    quadro(L1 + TW, C);
    quadro(L1 + TW + 1, C);
    quadro(L0 - TW, C);
    quadro(L0 - TW - 1, C);

    // Period window
    quadro(L0, 900);
    quadro(L0, C);
    quadro(L0, C + TP);
    quadro(L0, C + TP + 1);
    quadro(L0, C - TP);

    // Stuck high, then stuck low
    drive(1'b1, CMAX + 100);
    check("estado_preso_alto", int'(db_estado), 0);
    drive(1'b0, 100);
    quadro(L0, C);
    quadro(L1, C);
    drive(1'b1, L0);
    drive(1'b0, CMAX + 100);
    quadro(L0, C);
    quadro(L0, C);

    // Reset in the middle of a high pulse
    drive(1'b1, 100);
    @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    check("fila_antes_reset", fila.size(), 0);
    check_zero("reset_pulso");
    modelo_reset(1'b1);
    repeat (10) @(posedge clock);
    #2;
    reset = 1'b1;
    drive(1'b1, 150);
    drive(1'b0, 700);
    quadro(L1, C);
    quadro(L0, C);

    // Short glitch inside the high time
    drive(1'b1, 100);
    drive(1'b0, 2);
    drive(1'b1, L0 - 102);
    drive(1'b0, C - L0);
    quadro(L0, C);
    drive(1'b1, L0);
    drive(1'b0, 50);

    repeat (20) @(posedge clock);
    check("fila_pendente", fila.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
